// File: rtl/instr_fetch_unit.sv
// Purpose: owns the architectural PC, fetches one instruction at a time from imem, hands it to decode.
// Latency: 3 cycles per instruction minimum (request, wait for response, present to decode).
// Backpressure: decode stall holds the instruction in HOLD; no new request until it is accepted or redirected.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_resp_valid,
   input  logic [31:0]       imem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              misalign_err
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] redirect_target;
   logic              capture;

   // Redirect targets are forced word-aligned; the low bits only feed the error flag.
   assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

   assign imem_addr      = pc;
   assign imem_req_valid = (state == ST_REQ) && !redirect;
   assign inst_valid     = (state == ST_HOLD) && !redirect;

   // Next-state and next-PC decode; redirect wins over every other event.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;
      case (state)
         ST_REQ: begin
            if (redirect) begin
               pc_nxt = redirect_target;
            end else if (imem_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               // A response landing in the same cycle closes the outstanding request,
               // otherwise the stale response still has to be drained.
               pc_nxt    = redirect_target;
               state_nxt = imem_resp_valid ? ST_REQ : ST_DRAIN;
            end else if (imem_resp_valid) begin
               capture   = 1'b1;
               pc_nxt    = pc + ADDR_W'(4);
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_nxt    = redirect_target;
               state_nxt = ST_REQ;
            end else if (inst_ready) begin
               state_nxt = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (redirect) begin
               pc_nxt = redirect_target;
            end
            if (imem_resp_valid) begin
               state_nxt = ST_REQ;
            end
         end
         default: begin
            state_nxt = ST_REQ;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_REQ;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Instruction holding register, loaded only when a live response is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst    <= '0;
         inst_pc <= '0;
      end else if (capture) begin
         inst    <= imem_resp_data;
         inst_pc <= pc;
      end
   end

   // Sticky flag for any redirect target that was not word-aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         misalign_err <= 1'b1;
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential consumer of the next-PC value from PC_update: owns the architectural PC register and fetches instructions from instruction memory over a valid/ready request plus response-valid interface.
- Delivers each fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from the PC_update path and squashes any fetch in flight.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
ADDR_W, 32, PC/address width; instruction width is fixed at 32

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  ADDR_W  fetch address, equal to current PC
imem_resp_valid  input  1  response data valid; one response per accepted request, at least 1 cycle after acceptance
imem_resp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst  output  32  held instruction word
inst_pc  output  ADDR_W  PC of the held instruction
redirect  input  1  load redirect_pc as new PC and squash the current fetch
redirect_pc  input  ADDR_W  target from PC_update next_pc
misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=REQ, inst=0, inst_pc=0, misalign_err=0. Because imem_req_valid and inst_valid are decoded from state, they reset to 1 and 0 respectively.
- States: REQ, WAIT, HOLD, DRAIN.
- imem_addr = pc in all states.
- imem_req_valid = (state==REQ) && !redirect.
- inst_valid = (state==HOLD) && !redirect.
- REQ:
  - redirect: load pc, stay in REQ.
  - else imem_req_ready: go to WAIT.
  - else stay in REQ.
- WAIT:
  - redirect (with or without resp_valid): load pc, discard any response this cycle. If imem_resp_valid is 1 that cycle, go to REQ; else go to DRAIN.
  - else imem_resp_valid: inst<=imem_resp_data, inst_pc<=pc, pc<=pc+4, go to HOLD.
- HOLD:
  - redirect: load pc, drop the held instruction, go to REQ.
  - else inst_ready: go to REQ.
  - inst and inst_pc remain stable while in HOLD.
- DRAIN:
  - Wait for the stale response. On imem_resp_valid, discard the data and go to REQ.
  - A redirect in DRAIN reloads pc; a redirect coinciding with resp_valid still goes to REQ with the new pc.
- Redirect load: pc <= {redirect_pc[ADDR_W-1:2], 2'b00}. If redirect_pc[1:0] != 0, misalign_err <= 1 and stays 1 until rst.
- Throughput:
  - Minimum 3 cycles per instruction (REQ to WAIT to HOLD) when memory responds 1 cycle after acceptance and decode is ready.
  - At most one outstanding request.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFFFFFC wraps to 32'h00000000.
- Reset asserted mid-operation returns the block to REQ with pc=RESET_PC immediately (asynchronously). Responses arriving after reset for requests issued before reset must be suppressed by the memory model; the fetch unit does not track them.

Test Plan:
- Reset, then imem_req_ready=1, resp 1 cycle later with 32'h00500093, inst_ready=1 -> imem_addr 00000000, inst_valid with inst=00500093 and inst_pc=00000000, next request addr 00000004.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, imem_req_valid=0 throughout, no pc advance until inst_ready=1.
- Redirect to 00000440 while in WAIT, stale resp 32'hDEADBEEF arrives 2 cycles later -> state DRAIN, DEADBEEF never presented, next request addr 00000440.
- Redirect to 00001020 in HOLD together with inst_ready=1 -> inst_valid=0 that cycle, next imem_addr=00001020.
- Redirect to 00001FF2 -> misalign_err=1 (sticky), next imem_addr=00001FF0; misalign_err stays 1 until rst.
- Fetch at pc=FFFFFFFC completes -> next imem_addr=00000000; then assert rst in WAIT -> state REQ, imem_addr=RESET_PC, misalign_err=0.
